// File: rtl/rtc_pkg.sv
// Shared constants for the RTC time keeper and its key/mode controller:
// field packing of TIME/DATE/ALARM, MODE bit meanings, mode encodings,
// the reset date and the month-length helper.
package rtc_pkg;

    // TIME packing: [17] flag, [16:12] hour, [11:6] min, [5:0] sec
    localparam int unsigned TIME_FLAG_BIT = 17;
    localparam int unsigned TIME_HOUR_LSB = 12;
    localparam int unsigned TIME_MIN_LSB  = 6;
    localparam int unsigned TIME_SEC_LSB  = 0;
    localparam int unsigned HOUR_W        = 5;
    localparam int unsigned MIN_W         = 6;
    localparam int unsigned SEC_W         = 6;

    // DATE packing: [15:9] year, [8:5] month, [4:0] day
    localparam int unsigned DATE_YEAR_LSB = 9;
    localparam int unsigned DATE_MON_LSB  = 5;
    localparam int unsigned DATE_DAY_LSB  = 0;
    localparam int unsigned YEAR_W        = 7;
    localparam int unsigned MON_W         = 4;
    localparam int unsigned DAY_W         = 5;

    // MODE bit indices
    localparam int unsigned MODE_ALARM_SEL = 5;
    localparam int unsigned MODE_STOP      = 0;

    // Mode encodings shared with the key controller; every editing mode
    // freezes counting, only the alarm editor selects the alarm target.
    typedef enum logic [5:0] {
        RTC_RUN       = 6'b000000,
        RTC_SET_MIN   = 6'b000011,
        RTC_SET_HOUR  = 6'b000111,
        RTC_SET_DATE  = 6'b001111,
        RTC_SET_TIME  = 6'b011111,
        RTC_SET_ALARM = 6'b110011
    } rtc_mode_e;

    // Year 0, January 1st
    localparam logic [15:0] RESET_DATE = 16'h0021;

    // Month length; every year divisible by four is a leap year in 00-99
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                       input logic [YEAR_W-1:0] year);
        logic [DAY_W-1:0] days;
        case (month)
            4'd2:                    days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
            default:                 days = 5'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/rtc_time_keeper_prescaler.sv
// Divides CLK down to a one-cycle-per-second TICK.
module rtc_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic HOLD,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned CW = (TICKS_PER_SEC < 2) ? 1 : $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0] TERMINAL = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count 0..TERMINAL; HOLD parks the counter at 0, CLR restarts the second
    always_comb begin
        TICK = ~HOLD & (cnt_q == TERMINAL);
        if (HOLD | CLR) begin
            cnt_d = '0;
        end else if (cnt_q == TERMINAL) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_time_keeper.sv
// Running time, calendar date and alarm store for the RTC; loads edited
// values from the key controller and rings the alarm on a match.
module rtc_time_keeper #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned ALARM_SECS    = 30
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [5:0]  MODE,
    input  logic        SETTING,
    input  logic [17:0] LOAD_TIME,
    input  logic [15:0] LOAD_DATE,
    input  logic [16:0] LOAD_ALARM,
    input  logic        ALARM_ENABLE,
    output logic [17:0] TIME,
    output logic [15:0] DATE,
    output logic [16:0] ALARM_TIME,
    output logic        SEC_TICK,
    output logic        ALARM_HIT,
    output logic        ALARM_ACTIVE
);

    import rtc_pkg::*;

    localparam int unsigned ACW = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS + 1);

    logic              presc_tick;
    logic              set_edge, time_load, alarm_load, inc, match;

    logic              setting_armed_q, setting_armed_d;
    logic              flag_q, flag_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [MON_W-1:0]  mon_q, mon_d;
    logic [DAY_W-1:0]  day_q, day_d;
    logic [HOUR_W-1:0] al_hour_q, al_hour_d;
    logic [MIN_W-1:0]  al_min_q, al_min_d;
    logic [SEC_W-1:0]  al_sec_q, al_sec_d;
    logic              sec_tick_q, sec_tick_d;
    logic              alarm_hit_q, alarm_hit_d;
    logic              alarm_active_q, alarm_active_d;
    logic [ACW-1:0]    ring_cnt_q, ring_cnt_d;

    logic [HOUR_W-1:0] ld_hour, ld_al_hour, n_hour;
    logic [MIN_W-1:0]  ld_min, ld_al_min, n_min;
    logic [SEC_W-1:0]  ld_sec, ld_al_sec, n_sec;
    logic [YEAR_W-1:0] ld_year, n_year;
    logic [MON_W-1:0]  ld_mon, n_mon;
    logic [DAY_W-1:0]  ld_day, ld_dim, cur_dim, n_day;

    // MODE[4:1] select the controller's editing field and have no meaning here
    logic unused_mode_bits;
    assign unused_mode_bits = ^MODE[4:1];

    rtc_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
        .CLK    (CLK),
        .RESETN (RESETN),
        .HOLD   (MODE[MODE_STOP]),
        .CLR    (time_load),
        .TICK   (presc_tick)
    );

    // Load command decode and range-sanitised load values
    always_comb begin
        // armed = "SETTING was low last cycle"; resetting it to 0 keeps a
        // SETTING level held through reset from counting as a fresh edge
        set_edge        = SETTING & setting_armed_q;
        setting_armed_d = ~SETTING;
        time_load       = set_edge & ~MODE[MODE_ALARM_SEL];
        alarm_load      = set_edge &  MODE[MODE_ALARM_SEL];
        // only a time load restarts the second; an alarm load lets the tick through
        inc             = presc_tick & ~time_load;

        ld_hour = LOAD_TIME[TIME_HOUR_LSB +: HOUR_W];
        ld_min  = LOAD_TIME[TIME_MIN_LSB  +: MIN_W];
        ld_sec  = LOAD_TIME[TIME_SEC_LSB  +: SEC_W];
        if (ld_hour > 5'd23) ld_hour = '0;
        if (ld_min  > 6'd59) ld_min  = '0;
        if (ld_sec  > 6'd59) ld_sec  = '0;

        ld_year = LOAD_DATE[DATE_YEAR_LSB +: YEAR_W];
        ld_mon  = LOAD_DATE[DATE_MON_LSB  +: MON_W];
        ld_day  = LOAD_DATE[DATE_DAY_LSB  +: DAY_W];
        if (ld_year > 7'd99) ld_year = '0;
        if ((ld_mon == 4'd0) || (ld_mon > 4'd12)) ld_mon = 4'd1;
        ld_dim = days_in_month(ld_mon, ld_year);
        if (ld_day == 5'd0) begin
            ld_day = 5'd1;
        end else if (ld_day > ld_dim) begin
            ld_day = ld_dim;
        end

        ld_al_hour = LOAD_ALARM[TIME_HOUR_LSB +: HOUR_W];
        ld_al_min  = LOAD_ALARM[TIME_MIN_LSB  +: MIN_W];
        ld_al_sec  = LOAD_ALARM[TIME_SEC_LSB  +: SEC_W];
        if (ld_al_hour > 5'd23) ld_al_hour = '0;
        if (ld_al_min  > 6'd59) ld_al_min  = '0;
        if (ld_al_sec  > 6'd59) ld_al_sec  = '0;
    end

    // One-second increment with the full sec..year carry chain
    always_comb begin
        cur_dim = days_in_month(mon_q, year_q);
        n_hour  = hour_q;
        n_min   = min_q;
        n_sec   = sec_q;
        n_year  = year_q;
        n_mon   = mon_q;
        n_day   = day_q;
        if (sec_q >= 6'd59) begin
            n_sec = '0;
            if (min_q >= 6'd59) begin
                n_min = '0;
                if (hour_q >= 5'd23) begin
                    n_hour = '0;
                    if (day_q >= cur_dim) begin
                        n_day = 5'd1;
                        if (mon_q >= 4'd12) begin
                            n_mon  = 4'd1;
                            n_year = (year_q >= 7'd99) ? '0 : year_q + 7'd1;
                        end else begin
                            n_mon = mon_q + 4'd1;
                        end
                    end else begin
                        n_day = day_q + 5'd1;
                    end
                end else begin
                    n_hour = hour_q + 5'd1;
                end
            end else begin
                n_min = min_q + 6'd1;
            end
        end else begin
            n_sec = sec_q + 6'd1;
        end
    end

    // Next state: load beats increment; alarm match and ring countdown
    always_comb begin
        flag_d = LOAD_TIME[TIME_FLAG_BIT];
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        year_d = year_q;
        mon_d  = mon_q;
        day_d  = day_q;
        if (time_load) begin
            hour_d = ld_hour;
            min_d  = ld_min;
            sec_d  = ld_sec;
            year_d = ld_year;
            mon_d  = ld_mon;
            day_d  = ld_day;
        end else if (inc) begin
            hour_d = n_hour;
            min_d  = n_min;
            sec_d  = n_sec;
            year_d = n_year;
            mon_d  = n_mon;
            day_d  = n_day;
        end

        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        al_sec_d  = al_sec_q;
        if (alarm_load) begin
            al_hour_d = ld_al_hour;
            al_min_d  = ld_al_min;
            al_sec_d  = ld_al_sec;
        end

        match = inc & ALARM_ENABLE &
                ({n_hour, n_min, n_sec} == {al_hour_q, al_min_q, al_sec_q});

        alarm_active_d = alarm_active_q;
        ring_cnt_d     = ring_cnt_q;
        if (!ALARM_ENABLE) begin
            alarm_active_d = 1'b0;
            ring_cnt_d     = '0;
        end else if (match) begin
            alarm_active_d = 1'b1;
            ring_cnt_d     = ACW'(ALARM_SECS);
        end else if (inc && alarm_active_q) begin
            if (ring_cnt_q <= ACW'(1)) begin
                alarm_active_d = 1'b0;
                ring_cnt_d     = '0;
            end else begin
                ring_cnt_d = ring_cnt_q - ACW'(1);
            end
        end

        sec_tick_d  = inc;
        alarm_hit_d = match;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            setting_armed_q <= 1'b0;
            flag_q          <= 1'b0;
            hour_q          <= '0;
            min_q           <= '0;
            sec_q           <= '0;
            year_q          <= RESET_DATE[DATE_YEAR_LSB +: YEAR_W];
            mon_q           <= RESET_DATE[DATE_MON_LSB  +: MON_W];
            day_q           <= RESET_DATE[DATE_DAY_LSB  +: DAY_W];
            al_hour_q       <= '0;
            al_min_q        <= '0;
            al_sec_q        <= '0;
            sec_tick_q      <= 1'b0;
            alarm_hit_q     <= 1'b0;
            alarm_active_q  <= 1'b0;
            ring_cnt_q      <= '0;
        end else begin
            setting_armed_q <= setting_armed_d;
            flag_q          <= flag_d;
            hour_q          <= hour_d;
            min_q           <= min_d;
            sec_q           <= sec_d;
            year_q          <= year_d;
            mon_q           <= mon_d;
            day_q           <= day_d;
            al_hour_q       <= al_hour_d;
            al_min_q        <= al_min_d;
            al_sec_q        <= al_sec_d;
            sec_tick_q      <= sec_tick_d;
            alarm_hit_q     <= alarm_hit_d;
            alarm_active_q  <= alarm_active_d;
            ring_cnt_q      <= ring_cnt_d;
        end
    end

    assign TIME         = {flag_q, hour_q, min_q, sec_q};
    assign DATE         = {year_q, mon_q, day_q};
    assign ALARM_TIME   = {al_hour_q, al_min_q, al_sec_q};
    assign SEC_TICK     = sec_tick_q;
    assign ALARM_HIT    = alarm_hit_q;
    assign ALARM_ACTIVE = alarm_active_q;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Directed bench for rtc_time_keeper with 4 clocks per second and a
// 3-second ring; expected output snapshots go through a scoreboard queue.
module tb_rtc_time_keeper;

    import rtc_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [5:0]  MODE;
    logic        SETTING;
    logic [17:0] LOAD_TIME;
    logic [15:0] LOAD_DATE;
    logic [16:0] LOAD_ALARM;
    logic        ALARM_ENABLE;
    logic [17:0] TIME;
    logic [15:0] DATE;
    logic [16:0] ALARM_TIME;
    logic        SEC_TICK;
    logic        ALARM_HIT;
    logic        ALARM_ACTIVE;

    always #5 CLK = ~CLK;

    rtc_time_keeper #(.TICKS_PER_SEC(4), .ALARM_SECS(3)) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .MODE         (MODE),
        .SETTING      (SETTING),
        .LOAD_TIME    (LOAD_TIME),
        .LOAD_DATE    (LOAD_DATE),
        .LOAD_ALARM   (LOAD_ALARM),
        .ALARM_ENABLE (ALARM_ENABLE),
        .TIME         (TIME),
        .DATE         (DATE),
        .ALARM_TIME   (ALARM_TIME),
        .SEC_TICK     (SEC_TICK),
        .ALARM_HIT    (ALARM_HIT),
        .ALARM_ACTIVE (ALARM_ACTIVE)
    );

    // Observation vector: {TIME, DATE, ALARM_TIME, SEC_TICK, ALARM_HIT, ALARM_ACTIVE}
    localparam logic [53:0] MK_TIME = {18'h3FFFF, 36'd0};
    localparam logic [53:0] MK_DATE = {18'd0, 16'hFFFF, 20'd0};
    localparam logic [53:0] MK_ALRM = {34'd0, 17'h1FFFF, 3'd0};
    localparam logic [53:0] MK_TICK = 54'd4;
    localparam logic [53:0] MK_HIT  = 54'd2;
    localparam logic [53:0] MK_ACT  = 54'd1;
    localparam logic [53:0] MK_ALL  = '1;

    typedef struct {
        string       tag;
        logic [53:0] mask;
        logic [53:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    function automatic logic [17:0] tv(input logic f, input int unsigned h, input int unsigned m,
                                       input int unsigned s);
        return {f, 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [16:0] av(input int unsigned h, input int unsigned m,
                                       input int unsigned s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [15:0] dv(input int unsigned y, input int unsigned m,
                                       input int unsigned d);
        return {7'(y), 4'(m), 5'(d)};
    endfunction

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic exp_push(input string tag, input logic [53:0] mask, input logic [17:0] t,
                            input logic [15:0] d, input logic [16:0] a, input logic st,
                            input logic hit, input logic act);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.exp  = {t, d, a, st, hit, act};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [53:0] o;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed no entry, expected one");
        end else begin
            e = sb.pop_front();
            o = {TIME, DATE, ALARM_TIME, SEC_TICK, ALARM_HIT, ALARM_ACTIVE};
            assert ((o & e.mask) === (e.exp & e.mask)) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic wait_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc(1);
            if (SEC_TICK === 1'b1) seen = 1'b1;
        end
        n_assert++;
        assert (seen) else begin
            n_fail++;
            $error("FAIL %s: SEC_TICK observed 0 expected 1 within 12 cycles", tag);
        end
    endtask

    task automatic do_load(input logic [5:0] mode, input logic [17:0] t, input logic [15:0] d,
                           input logic [16:0] a);
        SETTING    = 1'b0;
        MODE       = mode;
        LOAD_TIME  = t;
        LOAD_DATE  = d;
        LOAD_ALARM = a;
        cyc(1);
        SETTING = 1'b1;
        cyc(1);
        SETTING = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETN       = 1'b0;
        MODE         = RTC_RUN;
        SETTING      = 1'b0;
        LOAD_TIME    = '0;
        LOAD_DATE    = '0;
        LOAD_ALARM   = '0;
        ALARM_ENABLE = 1'b0;
        cyc(3);

        exp_push("reset", MK_ALL, 18'd0, 16'h0021, 17'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        // First tick on the 4th edge after release, then every 4 cycles
        RESETN = 1'b1;
        exp_push("pre_tick", MK_TIME | MK_TICK, tv(0, 0, 0, 0), 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(3);
        check_out();
        exp_push("first_tick", MK_TIME | MK_TICK, tv(0, 0, 0, 1), 0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1);
        check_out();
        exp_push("tick_width", MK_TICK, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1);
        check_out();
        exp_push("three_ticks", MK_TIME | MK_DATE | MK_TICK, tv(0, 0, 0, 3), 16'h0021, 0,
                 1'b1, 1'b0, 1'b0);
        cyc(7);
        check_out();

        // Full wrap from 99-12-31 23:59:59, meridian flag carried through
        do_load(RTC_SET_TIME, tv(1, 23, 59, 59), dv(99, 12, 31), 0);
        exp_push("max_load", MK_TIME | MK_DATE | MK_TICK, tv(1, 23, 59, 59), dv(99, 12, 31), 0,
                 1'b0, 1'b0, 1'b0);
        check_out();
        MODE = RTC_RUN;
        exp_push("year_wrap", MK_TIME | MK_DATE, tv(1, 0, 0, 0), dv(0, 1, 1), 0,
                 1'b0, 1'b0, 1'b0);
        wait_tick("tick_year_wrap");
        check_out();

        // Leap and non-leap February, month-length clamp, field sanitising
        do_load(RTC_SET_TIME, tv(0, 23, 59, 59), dv(4, 2, 28), 0);
        MODE = RTC_RUN;
        exp_push("leap_feb29", MK_TIME | MK_DATE, tv(0, 0, 0, 0), dv(4, 2, 29), 0,
                 1'b0, 1'b0, 1'b0);
        wait_tick("tick_leap");
        check_out();
        do_load(RTC_SET_TIME, tv(0, 23, 59, 59), dv(5, 2, 28), 0);
        MODE = RTC_RUN;
        exp_push("nonleap_mar1", MK_TIME | MK_DATE, tv(0, 0, 0, 0), dv(5, 3, 1), 0,
                 1'b0, 1'b0, 1'b0);
        wait_tick("tick_nonleap");
        check_out();
        do_load(RTC_SET_TIME, tv(0, 10, 20, 30), dv(5, 4, 31), 0);
        exp_push("apr_clamp", MK_TIME | MK_DATE, tv(0, 10, 20, 30), dv(5, 4, 30), 0,
                 1'b0, 1'b0, 1'b0);
        check_out();
        do_load(RTC_SET_TIME, tv(0, 25, 61, 60), dv(120, 13, 0), 0);
        exp_push("sanitise", MK_TIME | MK_DATE, tv(0, 0, 0, 0), dv(0, 1, 1), 0,
                 1'b0, 1'b0, 1'b0);
        check_out();

        // Freeze for 20 cycles
        do_load(RTC_SET_TIME, tv(0, 10, 20, 30), dv(5, 4, 30), 0);
        MODE = 6'b000001;
        for (int i = 0; i < 20; i++) begin
            exp_push("freeze", MK_TIME | MK_TICK, tv(0, 10, 20, 30), 0, 0, 1'b0, 1'b0, 1'b0);
            cyc(1);
            check_out();
        end

        // Load edge coinciding with the terminal prescaler count
        MODE = RTC_RUN;
        exp_push("run_after_freeze", MK_TIME, tv(0, 10, 20, 31), 0, 0, 1'b0, 1'b0, 1'b0);
        wait_tick("tick_after_freeze");
        check_out();
        cyc(3);
        LOAD_TIME = tv(0, 12, 0, 0);
        LOAD_DATE = dv(5, 4, 30);
        SETTING   = 1'b1;
        exp_push("load_on_terminal", MK_TIME | MK_TICK, tv(0, 12, 0, 0), 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1);
        SETTING = 1'b0;
        check_out();
        exp_push("no_extra_inc", MK_TIME | MK_TICK, tv(0, 12, 0, 0), 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(3);
        check_out();
        exp_push("tick_after_load", MK_TIME | MK_TICK, tv(0, 12, 0, 1), 0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1);
        check_out();

        // Alarm at 00:00:05 rings for three seconds
        do_load(RTC_SET_TIME, tv(0, 0, 0, 4), dv(5, 4, 30), 0);
        do_load(RTC_SET_ALARM, tv(0, 9, 9, 9), dv(5, 4, 30), av(0, 0, 5));
        exp_push("alarm_load", MK_TIME | MK_ALRM, tv(0, 0, 0, 4), 0, av(0, 0, 5),
                 1'b0, 1'b0, 1'b0);
        check_out();
        ALARM_ENABLE = 1'b1;
        MODE         = RTC_RUN;
        exp_push("alarm_hit", MK_TIME | MK_HIT | MK_ACT, tv(0, 0, 0, 5), 0, 0, 1'b0, 1'b1, 1'b1);
        wait_tick("tick_alarm");
        check_out();
        exp_push("hit_one_cycle", MK_HIT | MK_ACT, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1);
        check_out();
        exp_push("ring_sec1", MK_TIME | MK_HIT | MK_ACT, tv(0, 0, 0, 6), 0, 0, 1'b0, 1'b0, 1'b1);
        wait_tick("tick_ring1");
        check_out();
        exp_push("ring_sec2", MK_TIME | MK_ACT, tv(0, 0, 0, 7), 0, 0, 1'b0, 1'b0, 1'b1);
        wait_tick("tick_ring2");
        check_out();
        exp_push("ring_done", MK_TIME | MK_HIT | MK_ACT, tv(0, 0, 0, 8), 0, 0, 1'b0, 1'b0, 1'b0);
        wait_tick("tick_ring3");
        check_out();

        // Loading the alarm time itself never matches
        do_load(RTC_SET_TIME, tv(0, 0, 0, 5), dv(5, 4, 30), 0);
        exp_push("load_no_match", MK_TIME | MK_HIT | MK_ACT, tv(0, 0, 0, 5), 0, 0,
                 1'b0, 1'b0, 1'b0);
        check_out();

        // Dropping ALARM_ENABLE mid-ring clears on the next edge
        do_load(RTC_SET_TIME, tv(0, 0, 0, 4), dv(5, 4, 30), 0);
        MODE = RTC_RUN;
        exp_push("hit_again", MK_HIT | MK_ACT, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        wait_tick("tick_hit_again");
        check_out();
        cyc(1);
        ALARM_ENABLE = 1'b0;
        exp_push("enable_drop", MK_ACT, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1);
        check_out();

        // Reset while ringing and while SETTING is high
        ALARM_ENABLE = 1'b1;
        do_load(RTC_SET_TIME, tv(0, 0, 0, 4), dv(5, 4, 30), 0);
        MODE = RTC_RUN;
        exp_push("ring_before_reset", MK_ACT, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        wait_tick("tick_before_reset");
        check_out();
        RESETN     = 1'b0;
        SETTING    = 1'b1;
        MODE       = RTC_SET_TIME;
        LOAD_TIME  = tv(1, 12, 34, 56);
        LOAD_DATE  = dv(7, 7, 7);
        LOAD_ALARM = av(1, 2, 3);
        exp_push("reset_mid_ring", MK_ALL, 18'd0, 16'h0021, 17'd0, 1'b0, 1'b0, 1'b0);
        cyc(1);
        check_out();
        RESETN = 1'b1;
        exp_push("no_load_after_reset", MK_ALL, tv(1, 0, 0, 0), 16'h0021, 17'd0,
                 1'b0, 1'b0, 1'b0);
        cyc(2);
        check_out();
        SETTING = 1'b0;
        cyc(1);
        SETTING = 1'b1;
        exp_push("load_after_rearm", MK_TIME | MK_DATE, tv(1, 12, 34, 56), dv(7, 7, 7), 0,
                 1'b0, 1'b0, 1'b0);
        cyc(1);
        check_out();
        SETTING = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_time_keeper.md
Name: rtc_time_keeper

Overview:
- Owns the running wall-clock time, calendar date and stored alarm time.
- Acts as the counterpart of the key/mode controller: it consumes that controller's MODE, SETTING, ALARM_ENABLE and edited OUT_* values, and returns the live time, date and alarm values the controller reads back as IN_*.
- Generates its own 1 Hz tick from CLK and raises an alarm strobe when the time matches the alarm.

Parameters:
- TICKS_PER_SEC, 100, CLK cycles per second; minimum 2.
- ALARM_SECS, 30, number of seconds ALARM_ACTIVE stays high after a match.

Ports:
- CLK  in  1  system clock
- RESETN  in  1  reset
- MODE  in  6  controller mode; bit5 = alarm(1)/current(0) target, bit0 = stop counting
- SETTING  in  1  commit level from the controller; its rising edge is the load command
- LOAD_TIME  in  18  [17] meridian/12h flag, [16:12] hour, [11:6] min, [5:0] sec
- LOAD_DATE  in  16  [15:9] year 0-99, [8:5] month, [4:0] day
- LOAD_ALARM  in  17  [16:12] hour, [11:6] min, [5:0] sec
- ALARM_ENABLE  in  1  alarm armed
- TIME  out  18  live time, same packing as LOAD_TIME
- DATE  out  16  live date
- ALARM_TIME  out  17  stored alarm
- SEC_TICK  out  1  one-cycle pulse on every seconds increment
- ALARM_HIT  out  1  one-cycle pulse on an alarm match
- ALARM_ACTIVE  out  1  alarm ringing

Behaviour:
- Reset: synchronous, active-low on RESETN; clock CLK.
- Reset values: TIME=0 (00:00:00, flag 0); DATE = year 0, month 1, day 1 (16'h0021); ALARM_TIME=0; SEC_TICK, ALARM_HIT, ALARM_ACTIVE = 0; prescaler = 0; SETTING edge register = 0.
- Reset asserted mid-operation (during a load or while ringing) aborts the operation and forces the reset values on the next edge.
- Prescaler: counts 0..TICKS_PER_SEC-1.
  - At the terminal count it wraps to 0 and, on that edge, increments seconds and pulses SEC_TICK.
  - While MODE[0]=1 (freeze), the prescaler holds at 0, there are no increments, and SEC_TICK=0.
- Rollover chain, all applied on the same edge:
  - sec 59 -> 0, carry to min
  - min 59 -> 0, carry to hour
  - hour 23 -> 0, carry to day
  - day = days_in_month -> 1, carry to month
  - month 12 -> 1, carry to year
  - year 99 -> 0
- days_in_month: 31/30 per month; February is 29 when year%4==0, else 28.
- TIME[17] is not counted. It follows LOAD_TIME[17] every cycle: 1-cycle registered copy, no SETTING needed.
- Load: set_edge = SETTING & ~SETTING_d. Latency is 1 cycle from the edge sample to the outputs.
  - MODE[5]=0: TIME[16:0] <= LOAD_TIME[16:0], DATE <= LOAD_DATE, prescaler <= 0.
  - MODE[5]=1: ALARM_TIME <= LOAD_ALARM; time and date are untouched and keep counting.
- Load sanitising: hour>23 -> 0; min or sec >59 -> 0; year>99 -> 0; month 0 or >12 -> 1; day 0 -> 1; day > days_in_month(loaded month, year) -> days_in_month. Alarm fields follow the same hour/min/sec rules.
- Simultaneous load and tick: the load wins, the tick is discarded and SEC_TICK=0.
- SETTING held high: no reloads after the first edge.
- Alarm match is evaluated only on an increment edge. The condition is ALARM_ENABLE=1 and the new TIME[16:0] == ALARM_TIME.
  - On a match: ALARM_HIT pulses 1 cycle, ALARM_ACTIVE=1 and a second counter loads ALARM_SECS.
  - ALARM_ACTIVE clears when the counter hits 0 (decremented on SEC_TICK), on ALARM_ENABLE=0 (next edge), or on reset.
  - A load never produces a match.
  - A re-match while active reloads the counter.

Decomposition:
- Package rtc_pkg holds:
  - field bit-position constants for the TIME/DATE/ALARM packing
  - MODE bit indices (MODE_ALARM_SEL=5, MODE_STOP=0)
  - the six mode encodings shared with the key controller
  - reset date constant
  - days_in_month(month, year) function
- One sub-module, rtc_prescaler (parameter TICKS_PER_SEC; inputs CLK, RESETN, HOLD, CLR; output TICK). The rollover, load and alarm logic stays in the top.

Test Plan:
- TICKS_PER_SEC=4: release reset, MODE=0 -> SEC_TICK every 4 cycles, first tick on cycle 4 after reset; after 3 ticks TIME[5:0]=3, DATE=16'h0021.
- Load TIME=23:59:59, DATE=year 99, month 12, day 31 via a SETTING edge with MODE=6'b011111 -> after 1 tick: TIME=0, DATE = year 0, month 1, day 1.
- Load year 4, Feb 28, 23:59:59 -> after 1 tick: Feb 29; reload with year 5 -> Mar 1. Load day 31 into Apr -> DATE day reads 30.
- MODE[0]=1 for 20 cycles -> TIME unchanged, SEC_TICK=0; SETTING edge landing on the terminal prescaler cycle -> loaded value appears, no extra increment.
- ALARM_SECS=3: MODE=6'b110011, load alarm 00:00:05, ALARM_ENABLE=1, time 00:00:04 -> on the next tick ALARM_HIT pulses once and ALARM_ACTIVE stays high for 3 ticks, then clears; repeat with ALARM_ENABLE dropped mid-ring -> clears on the next edge.
- Assert RESETN=0 while ALARM_ACTIVE=1 and while SETTING=1 -> all outputs at reset values on the next edge; after release a still-high SETTING causes no load.
